ma_lsu: RTL and testbench

//  Load/store unit between the memory-access stage and the external data memory.

---
 rtl/ma_lsu.sv | 156 +++++++++++++++
 tb/tb_ma_lsu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ma_lsu.sv
// rtl/ma_lsu.sv - load/store unit: aligns stores, extends loads, req/ack to data memory
module ma_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic          err_q;

  logic          legal;
  logic          misaligned;
  logic          idle_free;
  logic          accept;
  logic          reject;
  logic          timeout;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;

  always_comb begin
    if (req_we)
      legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    else
      legal = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // The cycle carrying a timeout err still presents the aborted instruction, so it is not re-accepted.
  assign idle_free = (state == S_IDLE) && !err_q;
  assign accept    = idle_free && req_valid && legal && !misaligned;
  assign reject    = idle_free && req_valid && !(legal && !misaligned);
  assign timeout   = (state == S_WAIT) && !mem_ack && (cnt == CNT_LAST);

  assign stall = !reset && (accept || (state == S_WAIT));
  assign err   = !reset && (reject || err_q);
  assign done  = (state == S_DONE);

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_n    = 4'b0001 << req_addr[1:0];
          wdata_n = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_n    = 4'b0011 << req_addr[1:0];
          wdata_n = {2{req_wdata[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      off_q     <= 2'd0;
      f3_q      <= 3'd0;
      err_q     <= 1'b0;
      rdata     <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wdata_n;
            off_q     <= req_addr[1:0];
            f3_q      <= req_funct3;
            cnt       <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we)
              rdata <= ld_data;
            state <= S_DONE;
          end else if (timeout) begin
            mem_req <= 1'b0;
            err_q   <= 1'b1;
            cnt     <= '0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_lsu.sv
// tb/tb_ma_lsu.sv - scoreboard bench for ma_lsu with a variable-latency memory responder
module tb_ma_lsu;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] rdata;
  logic        stall, done, err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  ma_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata), .stall(stall), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } mem_exp_t;

  typedef struct {
    logic        is_err;
    logic [31:0] rdata;
  } out_exp_t;

  mem_exp_t exp_mem[$];
  out_exp_t exp_out[$];
  mem_exp_t cur;

  int n_chk = 0;
  int n_fail = 0;
  int ack_delay = 0;
  logic [31:0] rd_word = 32'd0;
  int acnt = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic chk_w);
    mem_exp_t m;
    m.we = we; m.addr = addr; m.be = be; m.wdata = wdata; m.chk_wdata = chk_w;
    exp_mem.push_back(m);
  endtask

  task automatic push_out(input logic is_err, input logic [31:0] rd);
    out_exp_t o;
    o.is_err = is_err; o.rdata = rd;
    exp_out.push_back(o);
  endtask

  // Memory model: ack_delay=N acks in the Nth cycle mem_req is high; 0 never acks.
  always @(negedge clk) begin
    if (mem_req && !mem_ack) begin
      acnt++;
      if (ack_delay != 0 && acnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_word;
      end
    end else begin
      mem_ack = 1'b0;
      acnt    = 0;
    end
  end

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (done && err) chk("done_err_exclusive", 32'd1, 32'd0);
      if (mem_req && !prev_req) begin
        if (exp_mem.size() == 0) chk("unexpected_mem_req", 32'd1, 32'd0);
        else cur = exp_mem.pop_front();
      end
      if (mem_req) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
        if (cur.chk_wdata) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      if (done || err) begin
        if (exp_out.size() == 0) begin
          chk("unexpected_done_err", 32'd1, 32'd0);
        end else begin
          out_exp_t o;
          o = exp_out.pop_front();
          chk("err_kind", {31'd0, err}, {31'd0, o.is_err});
          if (done) chk("rdata", rdata, o.rdata);
        end
      end
    end
    prev_req = mem_req;
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int stalls);
    bit fin = 0;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    stalls = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      #3;
      if (done || err) begin
        chk("stall_at_end", {31'd0, stall}, 32'd0);
        fin = 1;
      end else begin
        if (stall) stalls++;
        @(negedge clk);
      end
    end
    if (!fin) chk("access_timeout", 32'd1, 32'd0);
    req_valid = 1'b0;
  endtask

  initial begin
    int s;
    #200000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    #2 reset = 1'b0;

    // SW with ack in the second mem_req cycle
    ack_delay = 2;
    push_mem(1, 32'h100, 4'b1111, 32'hDEADBEEF, 1); push_out(0, 32'h0);
    issue(1, 3'b010, 32'h100, 32'hDEADBEEF, s);
    chk("sw_stall_cycles", s, 32'd3);

    rd_word = 32'h80FF_1234; ack_delay = 1;
    push_mem(0, 32'h100, 4'b1111, 32'h0, 0); push_out(0, 32'hFFFFFF80);
    issue(0, 3'b000, 32'h103, 32'h0, s);
    chk("lb_stall_cycles", s, 32'd2);
    ack_delay = 3;
    push_mem(0, 32'h100, 4'b1111, 32'h0, 0); push_out(0, 32'h00000080);
    issue(0, 3'b100, 32'h103, 32'h0, s);
    push_mem(0, 32'h100, 4'b1111, 32'h0, 0); push_out(0, 32'hFFFF80FF);
    issue(0, 3'b001, 32'h102, 32'h0, s);
    ack_delay = 2;
    push_mem(0, 32'h100, 4'b1111, 32'h0, 0); push_out(0, 32'h000080FF);
    issue(0, 3'b101, 32'h102, 32'h0, s);
    push_mem(0, 32'h100, 4'b1111, 32'h0, 0); push_out(0, 32'h00000012);
    issue(0, 3'b000, 32'h101, 32'h0, s);
    rd_word = 32'h1234_5678;
    push_mem(0, 32'h104, 4'b1111, 32'h0, 0); push_out(0, 32'h12345678);
    issue(0, 3'b010, 32'h104, 32'h0, s);

    // stores leave rdata holding the last load
    push_mem(1, 32'h200, 4'b1100, 32'hABCDABCD, 1); push_out(0, 32'h12345678);
    issue(1, 3'b001, 32'h202, 32'h0000ABCD, s);
    push_mem(1, 32'h104, 4'b0010, 32'hA5A5A5A5, 1); push_out(0, 32'h12345678);
    issue(1, 3'b000, 32'h105, 32'h123456A5, s);

    push_out(1, 32'h0);
    issue(0, 3'b010, 32'h101, 32'h0, s);
    chk("misaligned_stalls", s, 32'd0);
    push_out(1, 32'h0); issue(0, 3'b001, 32'h201, 32'h0, s);
    push_out(1, 32'h0); issue(0, 3'b011, 32'h100, 32'h0, s);
    push_out(1, 32'h0); issue(0, 3'b110, 32'h100, 32'h0, s);
    push_out(1, 32'h0); issue(1, 3'b011, 32'h100, 32'h0, s);
    push_out(1, 32'h0); issue(1, 3'b010, 32'h102, 32'h0, s);
    @(negedge clk); #1;
    chk("no_mem_req_after_errs", {31'd0, mem_req}, 32'd0);

    ack_delay = 0;
    push_mem(0, 32'h300, 4'b1111, 32'h0, 0); push_out(1, 32'h0);
    issue(0, 3'b001, 32'h300, 32'h0, s);
    chk("timeout_stall_cycles", s, TO + 1);
    chk("timeout_mem_req", {31'd0, mem_req}, 32'd0);
    rd_word = 32'hCAFE_F00D; ack_delay = 1;
    push_mem(0, 32'h300, 4'b1111, 32'h0, 0); push_out(0, 32'hCAFEF00D);
    issue(0, 3'b010, 32'h300, 32'h0, s);

    // reset while an access is outstanding
    ack_delay = 0;
    push_mem(0, 32'h400, 4'b1111, 32'h0, 0);
    @(negedge clk);
    req_we = 0; req_funct3 = 3'b010; req_addr = 32'h400; req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk); #3 reset = 1'b0;
    rd_word = 32'h00C3_0000; ack_delay = 2;
    push_mem(0, 32'h100, 4'b1111, 32'h0, 0); push_out(0, 32'h000000C3);
    issue(0, 3'b100, 32'h102, 32'h0, s);

    repeat (3) @(negedge clk);
    chk("exp_out_drained", exp_out.size(), 32'd0);
    chk("exp_mem_drained", exp_mem.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
